// File: rtl/wb_register_file.sv
// Write-back stage register file: selects the write-back value, commits it, serves two read ports.
// Optional same-cycle write-before-read bypass is enabled by defining WB_BYPASS_EN.
module wb_register_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wbReadData,
  input  logic [DATA_W-1:0] wbAluResult,
  input  logic              wbRegWrite,
  input  logic              wbMemToReg,
  input  logic [ADDR_W-1:0] wbWriteReg,
  input  logic [ADDR_W-1:0] rs1Addr,
  input  logic [ADDR_W-1:0] rs2Addr,
  output logic [DATA_W-1:0] rs1Data,
  output logic [DATA_W-1:0] rs2Data,
  output logic [DATA_W-1:0] wbWriteData,
  output logic              wbCommit
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic              commit_q;
  logic              write_en;

  assign wbWriteData = wbMemToReg ? wbReadData : wbAluResult;
  assign write_en    = wbRegWrite && (wbWriteReg != '0);
  assign wbCommit    = commit_q;

  // Entry 0 is reset and never written, so it always holds zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
      commit_q <= 1'b0;
    end else begin
      if (write_en) begin
        regs_q[wbWriteReg] <= wbWriteData;
      end
      commit_q <= write_en;
    end
  end

`ifdef WB_BYPASS_EN
  // Bypass is suppressed while reset is held so reads return zero immediately.
  logic byp1, byp2;
  assign byp1 = rst_n && write_en && (rs1Addr == wbWriteReg);
  assign byp2 = rst_n && write_en && (rs2Addr == wbWriteReg);

  always_comb begin
    rs1Data = byp1 ? wbWriteData : regs_q[rs1Addr];
    rs2Data = byp2 ? wbWriteData : regs_q[rs2Addr];
  end
`else
  always_comb begin
    rs1Data = regs_q[rs1Addr];
    rs2Data = regs_q[rs2Addr];
  end
`endif

endmodule
